hyperram_wb_arbiter: RTL and testbench

HYPERRAM_WB_ARBITER -- requirements
Module: hyperram_wb_arbiter

---
 rtl/hyperram_arb_pkg.sv | 20 ++
 rtl/hyperram_wb_arbiter_rr_grant.sv | 30 +++
 rtl/hyperram_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_hyperram_wb_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperram_arb_pkg.sv
// Shared types and constants for the HyperRAM Wishbone arbiter.
// Holds the FSM state encoding, Wishbone CTI tags and bus field widths.
package hyperram_arb_pkg;

  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/hyperram_wb_arbiter_rr_grant.sv
// Combinational round-robin picker: returns the first requester after
// last_grant, wrapping from N-1 back to 0.
module rr_grant #(
  parameter int N  = 2,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          valid
);

  // Scan from lowest priority (last_grant itself) to highest (last_grant+1)
  // so the nearest requester after last_grant is written last and wins.
  always_comb begin : pick
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = N; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant = GW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyperram_wb_arbiter.sv
// Round-robin arbiter sharing one HyperRAM Wishbone slave port among
// NUM_MASTERS masters, with a per-access wait timeout that aborts with err.
module hyperram_wb_arbiter
  import hyperram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADR_W*NUM_MASTERS-1:0] m_adr,
  input  logic [DAT_W*NUM_MASTERS-1:0] m_dat_w,
  input  logic [SEL_W*NUM_MASTERS-1:0] m_sel,
  input  logic [NUM_MASTERS-1:0]       m_cyc,
  input  logic [NUM_MASTERS-1:0]       m_stb,
  input  logic [NUM_MASTERS-1:0]       m_we,
  input  logic [3*NUM_MASTERS-1:0]     m_cti,
  input  logic [2*NUM_MASTERS-1:0]     m_bte,
  output logic [DAT_W-1:0]             m_dat_r,
  output logic [NUM_MASTERS-1:0]       m_ack,
  output logic [NUM_MASTERS-1:0]       m_err,
  output logic [ADR_W-1:0]             s_adr,
  output logic [DAT_W-1:0]             s_dat_w,
  output logic [SEL_W-1:0]             s_sel,
  output logic                         s_cyc,
  output logic                         s_stb,
  output logic                         s_we,
  output logic [2:0]                   s_cti,
  output logic [1:0]                   s_bte,
  input  logic [DAT_W-1:0]             s_dat_r,
  input  logic                         s_ack,
  input  logic                         s_err,
  output arb_state_e                   dbg_state,
  output logic [$clog2(NUM_MASTERS)-1:0] dbg_grant
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);

  // Valid/ready: a master's access is offered while m_cyc&m_stb are high and
  // completes in the cycle its m_ack (or m_err) is high; grant holds while m_cyc stays high.
  arb_state_e    state, state_nx;
  logic [GW-1:0] grant, last_grant, pick;
  logic          pick_valid;
  logic [CW-1:0] wait_cnt;
  logic          abort_first;
  logic          g_cyc, g_stb, timeout_hit;

  rr_grant #(.N(NUM_MASTERS), .GW(GW)) u_rr_grant (
    .req        (m_cyc),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign g_cyc       = m_cyc[grant];
  assign g_stb       = m_stb[grant] & g_cyc;
  assign timeout_hit = (state == ST_BUSY) && g_stb && !s_ack && !s_err &&
                       (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (pick_valid) state_nx = ST_BUSY;
      ST_BUSY:  if (!g_cyc) state_nx = ST_IDLE;
                else if (timeout_hit) state_nx = ST_ABORT;
      ST_ABORT: if (!g_cyc) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= GW'(NUM_MASTERS - 1);
      wait_cnt    <= '0;
      abort_first <= 1'b0;
    end else begin
      state       <= state_nx;
      abort_first <= (state == ST_BUSY) && (state_nx == ST_ABORT);
      if (state == ST_IDLE && pick_valid) begin
        grant      <= pick;
        last_grant <= pick;
      end
      if (state != ST_BUSY || s_ack || s_err) wait_cnt <= '0;
      else if (g_stb) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Acks/errs are gated by the granted m_cyc so nothing reaches a master that has left.
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_cti   = '0;
    s_bte   = '0;
    m_ack   = '0;
    m_err   = '0;
    if (state == ST_BUSY) begin
      s_cyc   = g_cyc;
      s_stb   = g_stb;
      s_adr   = m_adr[int'(grant)*ADR_W +: ADR_W];
      s_dat_w = m_dat_w[int'(grant)*DAT_W +: DAT_W];
      s_sel   = m_sel[int'(grant)*SEL_W +: SEL_W];
      s_we    = m_we[grant];
      s_cti   = m_cti[int'(grant)*3 +: 3];
      s_bte   = m_bte[int'(grant)*2 +: 2];
      m_ack[grant] = s_ack & g_cyc;
      m_err[grant] = s_err & g_cyc;
    end else if (state == ST_ABORT) begin
      m_err[grant] = abort_first;
    end
  end

  assign m_dat_r   = s_dat_r;
  assign dbg_state = state;
  assign dbg_grant = grant;

endmodule

// File: tb/tb_hyperram_wb_arbiter.sv
// Self-checking bench for hyperram_wb_arbiter: ownership-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_hyperram_wb_arbiter;
  import hyperram_arb_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic            clock, reset;
  logic [N*30-1:0] m_adr;
  logic [N*32-1:0] m_dat_w;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [31:0]     m_dat_r;
  logic [N-1:0]    m_ack, m_err;
  logic [29:0]     s_adr;
  logic [31:0]     s_dat_w;
  logic [3:0]      s_sel;
  logic            s_cyc, s_stb, s_we;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [31:0]     s_dat_r;
  logic            s_ack, s_err;
  arb_state_e      dbg_state;
  logic [0:0]      dbg_grant;

  logic [29:0] adr_a[N];
  logic [31:0] dat_a[N];
  logic [3:0]  sel_a[N];
  logic        cyc_a[N], stb_a[N], we_a[N];
  logic [2:0]  cti_a[N];
  logic [1:0]  bte_a[N];

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  hyperram_wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_cti(m_cti), .m_bte(m_bte),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
    .dbg_state(dbg_state), .dbg_grant(dbg_grant)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_adr[i*30 +: 30]  = adr_a[i];
      m_dat_w[i*32 +: 32] = dat_a[i];
      m_sel[i*4 +: 4]    = sel_a[i];
      m_cyc[i]           = cyc_a[i];
      m_stb[i]           = stb_a[i];
      m_we[i]            = we_a[i];
      m_cti[i*3 +: 3]    = cti_a[i];
      m_bte[i*2 +: 2]    = bte_a[i];
    end
  end

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
  endtask

  // ---------------- slave responder ----------------
  int          slave_lat = 1;
  bit          no_ack    = 1'b0;
  logic [31:0] slave_dat = 32'h1000_0000;

  initial begin : slave
    int  slv_wait;
    bit  ack_nx;
    slv_wait = 0;
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
    forever begin
      @(negedge clock);
      ack_nx = 1'b0;
      if (reset || !(s_cyc && s_stb) || s_ack) slv_wait = 0;
      else begin
        slv_wait++;
        if (slv_wait >= slave_lat && !no_ack) ack_nx = 1'b1;
      end
      @(posedge clock); #1;
      s_ack = ack_nx;
      if (ack_nx) begin
        s_dat_r   = slave_dat;
        slave_dat = slave_dat + 1;
      end
    end
  end

  // ---------------- master driver ----------------
  bit          kill = 1'b0;
  logic [31:0] rdata_cap[N];

  task automatic run_master(input int i, input logic [29:0] adr, input logic we,
                            input int beats, input bit burst, input int drop_after);
    int acks  = 0;
    int cyc_n = 0;
    bit ack_s, err_s;
    @(posedge clock); #1;
    adr_a[i] = adr; we_a[i] = we; dat_a[i] = {2'b0, adr} ^ 32'h5A5A_0000;
    sel_a[i] = we ? 4'hF : 4'h3; bte_a[i] = 2'b00;
    cti_a[i] = !burst ? CTI_CLASSIC : (beats == 1 ? CTI_END : CTI_INCR);
    cyc_a[i] = 1'b1; stb_a[i] = 1'b1;
    forever begin
      @(negedge clock);
      ack_s = m_ack[i];
      err_s = m_err[i];
      if (ack_s) rdata_cap[i] = m_dat_r;
      @(posedge clock); #1;
      cyc_n++;
      if (kill || err_s) break;
      if (ack_s) begin
        acks++;
        if (acks == beats || acks == drop_after) break;
        adr_a[i] = adr_a[i] + 1;
        dat_a[i] = dat_a[i] + 1;
        if (burst && acks == beats - 1) cti_a[i] = CTI_END;
      end
      if (cyc_n > 300) begin
        checks++; errors++;
        $display("FAIL master_wait m%0d actual=no_response required=ack", i);
        break;
      end
    end
    cyc_a[i] = 1'b0; stb_a[i] = 1'b0; cti_a[i] = CTI_CLASSIC;
  endtask

  // ---------------- model + per-cycle compare ----------------
  int own = -1, last_own = N - 1, unanswered = 0;
  bit in_abort = 1'b0, err_due = 1'b0;
  int ack_cnt[N], err_cnt[N];
  int stb_cnt = 0, stb_snap = 0;
  time t_m = 0, t_s = 0;
  bit prev_mcyc0 = 1'b0, prev_scyc = 1'b0;
  arb_state_e prev_st = ST_IDLE;

  always @(negedge clock) begin : compare
    logic [N-1:0] e_ack, e_err;
    arb_state_e e_st;
    bit busy, found;
    int c;
    if (reset) begin
      chk("rst_s_cyc_stb", {s_cyc, s_stb}, 0);
      chk("rst_m_ack_err", {m_ack, m_err}, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      own = -1; last_own = N - 1; unanswered = 0; in_abort = 0; err_due = 0;
      prev_st = ST_IDLE;
    end else begin
      busy  = (own >= 0) && !in_abort;
      e_ack = '0;
      e_err = '0;
      if (busy && cyc_a[own]) begin
        e_ack[own] = s_ack;
        e_err[own] = s_err;
      end
      if (in_abort) e_err[own] = err_due;
      e_st = (own < 0) ? ST_IDLE : (in_abort ? ST_ABORT : ST_BUSY);
      chk("state", dbg_state, e_st);
      if (own >= 0) chk("grant", dbg_grant, own);
      chk("s_cyc", s_cyc, busy ? cyc_a[own] : 1'b0);
      chk("s_stb", s_stb, busy ? (cyc_a[own] & stb_a[own]) : 1'b0);
      chk("s_adr_we", {s_adr, s_we}, busy ? {adr_a[own], we_a[own]} : 31'h0);
      chk("s_dat_w", s_dat_w, busy ? dat_a[own] : 32'h0);
      chk("s_sel_cti_bte", {s_sel, s_cti, s_bte}, busy ? {sel_a[own], cti_a[own], bte_a[own]} : 9'h0);
      chk("m_ack", m_ack, e_ack);
      chk("m_err", m_err, e_err);
      chk("m_dat_r", m_dat_r, s_dat_r);
      if (dbg_state == ST_BUSY && prev_st != ST_BUSY) begin
        if (exp_q.size() > 0) chk("grant_order", dbg_grant, exp_q.pop_front());
        else chk("grant_unexpected", 1, 0);
      end
      prev_st = dbg_state;
      // advance the ownership model with the inputs the coming edge will see
      if (own < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (last_own + k) % N;
          if (cyc_a[c] && !found) begin own = c; found = 1'b1; end
        end
        if (found) begin last_own = own; unanswered = 0; end
      end else if (!in_abort) begin
        if (!cyc_a[own]) own = -1;
        else if (s_ack || s_err) unanswered = 0;
        else if (stb_a[own]) begin
          unanswered++;
          if (unanswered == TMO) begin in_abort = 1; err_due = 1; unanswered = 0; end
        end
      end else begin
        err_due = 0;
        if (!cyc_a[own]) begin own = -1; in_abort = 0; end
      end
    end
    for (int i = 0; i < N; i++) begin
      ack_cnt[i] += int'(m_ack[i]);
      err_cnt[i] += int'(m_err[i]);
    end
    stb_cnt += int'(s_cyc & s_stb);
    if (m_err[0]) stb_snap = stb_cnt;
    if (cyc_a[0] && !prev_mcyc0) t_m = $time;
    if (s_cyc && !prev_scyc) t_s = $time;
    prev_mcyc0 = cyc_a[0];
    prev_scyc  = s_cyc;
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int a0, a1, e0, sb;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      adr_a[i] = '0; dat_a[i] = '0; sel_a[i] = '0; cyc_a[i] = 0;
      stb_a[i] = 0; we_a[i] = 0; cti_a[i] = '0; bte_a[i] = '0;
      ack_cnt[i] = 0; err_cnt[i] = 0; rdata_cap[i] = '0;
    end
    #1;
    chk("reset_s_cyc", s_cyc, 0);
    do_reset();

    // single classic read, ack in the third strobed cycle
    slave_lat = 2; slave_dat = 32'hDEAD_BEEF;
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    exp_q.push_back(1'b0);
    run_master(0, 30'h100, 1'b0, 1, 1'b0, 0);
    repeat (3) @(posedge clock);
    chk("t1_ack0", ack_cnt[0] - a0, 1);
    chk("t1_ack1", ack_cnt[1] - a1, 0);
    chk("t1_rdata", rdata_cap[0], 32'hDEAD_BEEF);
    chk("t1_s_cyc_latency", t_s - t_m, 10);

    // both masters, four single accesses each, alternating grants
    do_reset();
    slave_lat = 1;
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    for (int k = 0; k < 4; k++) begin exp_q.push_back(1'b0); exp_q.push_back(1'b1); end
    fork
      for (int k = 0; k < 4; k++) run_master(0, 30'h200 + 30'(k), 1'b1, 1, 1'b0, 0);
      for (int k = 0; k < 4; k++) run_master(1, 30'h300 + 30'(k), 1'b0, 1, 1'b0, 0);
    join
    repeat (3) @(posedge clock);
    chk("t2_ack0", ack_cnt[0] - a0, 4);
    chk("t2_ack1", ack_cnt[1] - a1, 4);

    // master 1 burst of 8 while master 0 waits
    do_reset();
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    fork
      run_master(1, 30'h400, 1'b0, 8, 1'b1, 0);
      begin @(posedge clock); run_master(0, 30'h500, 1'b1, 1, 1'b0, 0); end
    join
    repeat (3) @(posedge clock);
    chk("t3_ack1_burst", ack_cnt[1] - a1, 8);
    chk("t3_ack0", ack_cnt[0] - a0, 1);

    // timeout abort on master 0, then master 1 served
    do_reset();
    no_ack = 1'b1;
    a0 = ack_cnt[0]; a1 = ack_cnt[1]; e0 = err_cnt[0]; sb = stb_cnt;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    fork
      run_master(0, 30'h600, 1'b0, 1, 1'b0, 0);
      begin @(posedge clock); run_master(1, 30'h700, 1'b0, 1, 1'b0, 0); end
      begin
        for (int k = 0; k < 100; k++) begin
          @(posedge clock);
          if (err_cnt[0] > e0) break;
        end
        no_ack = 1'b0;
      end
    join
    repeat (3) @(posedge clock);
    chk("t4_err0", err_cnt[0] - e0, 1);
    chk("t4_strobes_before_abort", stb_snap - sb, TMO);
    chk("t4_ack0", ack_cnt[0] - a0, 0);
    chk("t4_ack1", ack_cnt[1] - a1, 1);

    // asynchronous reset in the middle of a master 0 burst
    do_reset();
    a0 = ack_cnt[0];
    exp_q.push_back(1'b0);
    fork
      run_master(0, 30'h800, 1'b0, 8, 1'b1, 0);
      begin
        for (int k = 0; k < 100; k++) begin
          @(posedge clock);
          if (ack_cnt[0] - a0 >= 3) break;
        end
        chk("t5_beats_before_reset", ack_cnt[0] - a0 >= 3, 1);
        #3 reset = 1'b1;
        #1;
        chk("t5_async_s_cyc_stb", {s_cyc, s_stb}, 0);
        chk("t5_async_m_ack_err", {m_ack, m_err}, 0);
        kill = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
      end
    join
    kill = 1'b0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    fork
      run_master(0, 30'h900, 1'b0, 1, 1'b0, 0);
      run_master(1, 30'hA00, 1'b0, 1, 1'b0, 0);
    join
    repeat (3) @(posedge clock);

    // master drops its cycle after 2 of 4 burst beats
    do_reset();
    a1 = ack_cnt[1];
    exp_q.push_back(1'b1);
    run_master(1, 30'hB00, 1'b0, 4, 1'b1, 2);
    #1;
    chk("t6_s_cyc_drop", s_cyc, 0);
    @(posedge clock); #1;
    chk("t6_idle_after_drop", dbg_state, ST_IDLE);
    repeat (4) @(posedge clock);
    chk("t6_ack1", ack_cnt[1] - a1, 2);

    chk("grant_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
